ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Keyboard front end that produces the held-key levels raw_left, raw_right, raw_down, raw_rotate and raw_drop, which input_manager consumes.
- Receives PS/2 scan-code set 2 frames from the keyboard and tracks make/break codes, including the E0 extended and F0 break prefixes.
- Drives one registered level per game key.
- Sits between the board PS/2 pins and input_manager, in the clk domain.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on ps2_clk and ps2_data.
- FILTER_LEN, 8: number of cycles the synchronised ps2_clk must be stable before the filtered clock changes.
- TIMEOUT_CYCLES, 100000: idle cycles allowed mid-frame before the frame is aborted (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- raw_left  out  1  level; E0 6B (left arrow) is held.
- raw_right  out  1  level; E0 74 (right arrow) is held.
- raw_down  out  1  level; E0 72 (down arrow) is held.
- raw_rotate  out  1  level; E0 75 (up arrow) is held.
- raw_drop  out  1  level; 29 (space) is held.
- key_valid  out  1  one-cycle pulse per accepted byte.
- key_code  out  8  last accepted byte; valid while key_valid is high, held otherwise.
- frame_err  out  1  one-cycle pulse per rejected or aborted frame.

Behaviour:
- Reset: all outputs are 0, key_code is 0x00. Frame FSM goes to IDLE, ext/brk flags clear, filtered clock is 1. A reset asserted mid-frame discards the partial byte and releases all keys.
- Input conditioning:
  - Both pins pass through SYNC_STAGES flops.
  - ps2_clk_f takes the synchronised value only after FILTER_LEN consecutive equal samples.
  - A falling edge of ps2_clk_f is the sample strobe.
- Frame FSM: IDLE -> RX -> DONE -> IDLE; an 11-bit frame is counted with bit_cnt 0..10.
  - Bit 0 is the start bit and must be 0. If it is 1, pulse frame_err and stay in IDLE.
  - Bits 1-8 are data, LSB first, shifted into an 8-bit register.
  - Bit 9 is parity (see Optional Feature).
  - Bit 10 is the stop bit and must be 1. If it is 0, pulse frame_err, discard the byte and return to IDLE.
  - Good stop bit on strobe cycle N: DONE for one cycle; key_valid=1 and key_code=byte in cycle N+1.
- Timeout: in RX with no strobe for TIMEOUT_CYCLES cycles, the FSM returns to IDLE, pulses frame_err and clears the ext/brk flags. The counter resets on every strobe.
- Decode, applied to each byte accepted in cycle N+1; raw_* are updated in cycle N+2.
  - 0xE0 sets ext. 0xF0 sets brk. Neither changes any raw_* output.
  - Any other byte looks up (ext, byte):
    - If it matches a key, that raw_* is set to !brk.
    - Unmatched codes change nothing. This includes non-extended 6B/74/72/75 (keypad keys), 0xAA (BAT pass) and 0xFA (ACK).
    - ext and brk clear after any non-prefix byte, whether matched or not.
  - A rejected frame clears ext and brk.
- Repeated make codes from typematic repeat leave the level at 1. No pulses are generated here; edge/DAS shaping belongs to input_manager.
- Any number of keys may be held at once; each level is independent.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: bit 9 must make bits 1-9 odd parity. If it does not, the frame is discarded at the stop bit, frame_err pulses, key_valid does not pulse and ext/brk clear.
- Undefined: bit 9 is sampled and ignored.

Decomposition:
- Package ps2_pkg holds:
  - scan-code constants: SC_EXT=8'hE0, SC_BREAK=8'hF0, SC_LEFT=8'h6B, SC_RIGHT=8'h74, SC_DOWN=8'h72, SC_UP=8'h75, SC_SPACE=8'h29;
  - the frame FSM enum (IDLE, RX, DONE).
- Sub-module ps2_rx_frame (sync, filter, frame FSM, timeout, parity; outputs byte/valid/err). The top level holds the prefix flags and the key-level registers.

Test Plan:
- Bytes E0,6B, then E0,F0,6B: raw_left rises 2 cycles after the 6B stop strobe, then falls 2 cycles after the second 6B stop strobe. key_valid pulses 5 times. Other raw_* stay 0.
- Byte 29, then E0,75 held, then F0,29: raw_drop=1 and raw_rotate=1 simultaneously; after F0,29, raw_drop=0 while raw_rotate stays 1.
- Non-extended 6B, then AA, then FA: key_valid pulses 3 times with those codes; all raw_* unchanged at 0.
- Frame with stop bit 0 carrying 6B after E0: frame_err pulses, no key_valid; a following good 6B (ext now cleared) leaves raw_left=0.
- Start bit then 5 bits, then idle: frame_err pulses TIMEOUT_CYCLES cycles after the last strobe. A following good E0,74 sets raw_right=1.
- With PS2_PARITY_CHECK_EN defined, byte 29 with even parity: frame_err pulses and raw_drop stays 0. Without the macro, the same frame sets raw_drop=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - scan-code constants, frame FSM states and helpers for the PS/2 key decoder
package ps2_pkg;

  // Scan-code set 2 bytes recognised by the decoder
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Bit positions inside the held-key vector
  localparam int KEY_DROP   = 0;
  localparam int KEY_ROTATE = 1;
  localparam int KEY_DOWN   = 2;
  localparam int KEY_RIGHT  = 3;
  localparam int KEY_LEFT   = 4;

  // Frame receiver states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_DONE = 2'd2
  } frame_state_t;

  // True when the 9 bits (8 data + parity) hold an odd number of ones
  function automatic logic odd_parity(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 pin sync/filter and 11-bit frame receiver; parity check under PS2_PARITY_CHECK_EN
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_s;
  logic                   data_s;

  logic [FW-1:0] filt_cnt_q;
  logic          clk_f_q;
  logic          clk_f_prev_q;
  logic          strobe;

  frame_state_t  state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          parity_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q, parity_d;
  assign parity_ok = odd_parity({shift_q, parity_q});
`else
  assign parity_ok = 1'b1;
`endif

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign strobe = clk_f_prev_q & ~clk_f_q;

  // Bring both pins into the clk domain; idle bus level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
    end
  end

  // Filtered clock follows the synced clock only after FILTER_LEN differing samples in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt_q   <= '0;
      clk_f_q      <= 1'b1;
      clk_f_prev_q <= 1'b1;
    end else begin
      clk_f_prev_q <= clk_f_q;
      if (clk_s == clk_f_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_f_q    <= clk_s;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  // Frame FSM: start bit in IDLE, data/parity/stop in RX, one DONE cycle per good byte
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    timer_d   = timer_q;
    err_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (strobe) begin
          if (!data_s) begin
            state_d   = ST_RX;
            bit_cnt_d = 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RX: begin
        if (strobe) begin
          timer_d   = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd8) begin
            shift_d = {data_s, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd9) begin
`ifdef PS2_PARITY_CHECK_EN
            parity_d = data_s;
`endif
          end else begin
            if (data_s && parity_ok) begin
              state_d = ST_DONE;
              byte_d  = shift_q;
            end else begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = (state_q == ST_DONE);
  assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 make/break decoder driving held game-key levels; PS2_PARITY_CHECK_EN enables parity rejection
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       raw_left,
  output logic       raw_right,
  output logic       raw_down,
  output logic       raw_rotate,
  output logic       raw_drop,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [4:0] keys_q, keys_d;

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_err)
  );

  // Prefix tracking and key lookup; prefixes only arm flags, any other byte consumes them
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    keys_d = keys_q;
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        if (ext_q) begin
          case (rx_byte)
            SC_LEFT:  keys_d[KEY_LEFT]   = ~brk_q;
            SC_RIGHT: keys_d[KEY_RIGHT]  = ~brk_q;
            SC_DOWN:  keys_d[KEY_DOWN]   = ~brk_q;
            SC_UP:    keys_d[KEY_ROTATE] = ~brk_q;
            default:  ;
          endcase
        end else if (rx_byte == SC_SPACE) begin
          keys_d[KEY_DROP] = ~brk_q;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Prefix flags and held-key levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      keys_q <= '0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      keys_q <= keys_d;
    end
  end

  assign raw_left   = keys_q[KEY_LEFT];
  assign raw_right  = keys_q[KEY_RIGHT];
  assign raw_down   = keys_q[KEY_DOWN];
  assign raw_rotate = keys_q[KEY_ROTATE];
  assign raw_drop   = keys_q[KEY_DROP];
  assign key_valid  = rx_valid;
  assign key_code   = rx_byte;
  assign frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed and randomized PS/2 frames checked against a key-state model
module tb_ps2_key_decoder;

  localparam int TMO  = 400;
  localparam int HALF = 20;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       raw_left, raw_right, raw_down, raw_rotate, raw_drop;
  logic       key_valid, frame_err;
  logic [7:0] key_code;

  ps2_key_decoder #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .raw_left  (raw_left),
    .raw_right (raw_right),
    .raw_down  (raw_down),
    .raw_rotate(raw_rotate),
    .raw_drop  (raw_drop),
    .key_valid (key_valid),
    .key_code  (key_code),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   kv_cnt = 0, err_cnt = 0, kv_cyc = 0, err_cyc = 0, left_chg_cyc = 0;
  logic left_prev = 1'b0;
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin kv_cnt++; kv_cyc = cyc; end
    if (frame_err === 1'b1) begin err_cnt++; err_cyc = cyc; end
    if (raw_left !== left_prev) left_chg_cyc = cyc;
    left_prev = raw_left;
  end

  // Reference model: held keys as {left,right,down,rotate,drop}
  logic [4:0] m_keys = '0;
  logic [7:0] m_code = 8'h00;
  bit         m_ext = 0, m_brk = 0;
  int         m_kv = 0, m_err = 0;
  int         vectors = 0, miscompares = 0;

  function automatic int key_index(input bit ext, input logic [7:0] b);
    if (ext && b == 8'h6B) return 4;
    if (ext && b == 8'h74) return 3;
    if (ext && b == 8'h72) return 2;
    if (ext && b == 8'h75) return 1;
    if (!ext && b == 8'h29) return 0;
    return -1;
  endfunction

  task automatic model_frame(input logic [7:0] b, input bit accepted);
    int k;
    if (!accepted) begin
      m_err++; m_ext = 0; m_brk = 0;
      return;
    end
    m_kv++;
    m_code = b;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = key_index(m_ext, b);
      if (k >= 0) m_keys[k] = !m_brk;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic pulse_bit(input logic d);
    ps2_data = d;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    logic [10:0] bits;
    bits[0]    = 1'b0;
    bits[8:1]  = b;
    bits[9]    = (~^b) ^ bad_par;
    bits[10]   = ~bad_stop;
    for (int i = 0; i < 11; i++) pulse_bit(bits[i]);
    ps2_data = 1'b1;
    repeat (40) @(negedge clk);
    model_frame(b, !bad_stop && !(PAR_EN && bad_par));
  endtask

  task automatic check(input string tag);
    logic [4:0] rawv;
    rawv = {raw_left, raw_right, raw_down, raw_rotate, raw_drop};
    vectors++;
    assert (rawv === m_keys) else begin
      miscompares++; $error("FAIL %s raw obs=%b exp=%b", tag, rawv, m_keys);
    end
    vectors++;
    assert (kv_cnt === m_kv) else begin
      miscompares++; $error("FAIL %s key_valid_count obs=%0d exp=%0d", tag, kv_cnt, m_kv);
    end
    vectors++;
    assert (err_cnt === m_err) else begin
      miscompares++; $error("FAIL %s frame_err_count obs=%0d exp=%0d", tag, err_cnt, m_err);
    end
    vectors++;
    assert (key_code === m_code) else begin
      miscompares++; $error("FAIL %s key_code obs=%h exp=%h", tag, key_code, m_code);
    end
  endtask

  task automatic check_left_timing(input string tag);
    int d;
    d = left_chg_cyc - kv_cyc;
    vectors++;
    assert (d === 1) else begin
      miscompares++; $error("FAIL %s left_latency obs=%0d exp=1", tag, d);
    end
  endtask

  initial begin
    logic [7:0] pool [9];
    logic [7:0] b;
    int         e0, fall_cyc, dly;
    bit         in_win;
    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h72, 8'h75, 8'h29, 8'hAA, 8'hFA};

    // Reset state
    repeat (5) @(negedge clk);
    check("reset");
    vectors++;
    assert ({key_valid, frame_err} === 2'b00) else begin
      miscompares++; $error("FAIL reset_pulses obs=%b exp=00", {key_valid, frame_err});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Left arrow make then break, with exact latency
    send_frame(8'hE0, 0, 0); send_frame(8'h6B, 0, 0);
    check("left_make"); check_left_timing("left_make");
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h6B, 0, 0);
    check("left_break"); check_left_timing("left_break");

    // Space and up arrow held together, then space released
    send_frame(8'h29, 0, 0); send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    check("drop_rotate_held");
    send_frame(8'hF0, 0, 0); send_frame(8'h29, 0, 0);
    check("drop_released");

    // Keypad codes, BAT pass and ACK are accepted but unmatched
    send_frame(8'h6B, 0, 0); check("keypad_6b");
    send_frame(8'hAA, 0, 0); check("bat_aa");
    send_frame(8'hFA, 0, 0); check("ack_fa");

    // Bad stop bit after E0 drops the prefix
    send_frame(8'hE0, 0, 0); send_frame(8'h6B, 1, 0); check("bad_stop");
    send_frame(8'h6B, 0, 0); check("after_bad_stop");

    // Mid-frame timeout after E0, then 74 alone is keypad, then E0 74 is right arrow
    send_frame(8'hE0, 0, 0);
    e0 = err_cnt;
    pulse_bit(1'b0);
    for (int i = 0; i < 5; i++) pulse_bit(i[0]);
    fall_cyc = cyc - HALF;
    ps2_data = 1'b1;
    for (int i = 0; i < TMO + 300 && err_cnt == e0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    dly = err_cyc - fall_cyc;
    in_win = (dly >= TMO) && (dly <= TMO + 25);
    vectors++;
    assert (in_win === 1'b1) else begin
      miscompares++; $error("FAIL timeout_delay obs=%0d exp=%0d..%0d", dly, TMO, TMO + 25);
    end
    model_frame(8'h00, 0);
    check("timeout");
    send_frame(8'h74, 0, 0); check("keypad_74_after_timeout");
    send_frame(8'hE0, 0, 0); send_frame(8'h74, 0, 0); check("right_make");

    // Parity error on space
    send_frame(8'h29, 0, 1); check("parity_space");

    // Start bit of 1 is rejected in idle and clears a pending prefix
    send_frame(8'hE0, 0, 0);
    pulse_bit(1'b1);
    repeat (40) @(negedge clk);
    model_frame(8'h00, 0);
    check("bad_start");
    send_frame(8'h72, 0, 0); check("72_after_bad_start");

    // Reset mid-frame releases everything
    send_frame(8'hE0, 0, 0); send_frame(8'h72, 0, 0); check("down_make");
    pulse_bit(1'b0); pulse_bit(1'b1); pulse_bit(1'b0);
    ps2_data = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    m_keys = '0; m_code = 8'h00; m_ext = 0; m_brk = 0;
    check("reset_mid_frame");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(8'hE0, 0, 0); send_frame(8'h72, 0, 0); check("recover_after_reset");

    // Randomized byte stream with occasional framing and parity faults
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 8)];
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      check($sformatf("rand_%0d_%h", n, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
